// File: rtl/izh_neuron_scheduler.sv
// rtl/izh_neuron_scheduler.sv - time-multiplexed Izhikevich neuron slot scheduler
module izh_neuron_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    init,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic signed [7:0]       cfg_current,
  input  logic [3:0]              cfg_type,
  output logic                    dp_req,
  output logic signed [17:0]      dp_v,
  output logic signed [17:0]      dp_u,
  output logic signed [7:0]       dp_current,
  output logic [3:0]              dp_type,
  input  logic                    dp_ack,
  input  logic signed [17:0]      dp_v_next,
  input  logic signed [17:0]      dp_u_next,
  input  logic                    dp_spike,
  output logic                    busy,
  output logic                    sweep_done,
  output logic [NUM_NEURONS-1:0]  spike_vec,
  output logic                    overrun
);

  localparam logic signed [17:0] V_REST   = 18'sh3_4CCD;
  localparam logic signed [17:0] U_REST   = 18'sh3_CCCD;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_NEURONS - 1);
  localparam logic [3:0]         MAX_TYPE = 4'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic signed [17:0] v_mem [NUM_NEURONS];
  logic signed [17:0] u_mem [NUM_NEURONS];
  logic signed [7:0]  cur_mem [NUM_NEURONS];
  logic [3:0]         typ_mem [NUM_NEURONS];

  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_inc;
  logic [NUM_NEURONS-1:0] acc;
  logic                   start;
  logic                   ack_ok;
  logic                   last;
  logic                   cfg_hit;
  logic                   init_ok;

  assign idx_inc = idx + IDX_W'(1);
  assign last    = (idx == LAST_IDX);
  assign cfg_hit = cfg_we && ({1'b0, cfg_addr} < (IDX_W+1)'(NUM_NEURONS));

  // init has priority over tick in IDLE; both are ignored once a sweep is running
  always_comb begin
    start  = 1'b0;
    ack_ok = 1'b0;
    init_ok = 1'b0;
    if (state == S_IDLE) begin
      init_ok = init;
      start   = tick && !init;
    end
    if (state == S_ISSUE) begin
      ack_ok = dp_ack;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dp_req     = 1'b0;
    busy       = 1'b0;
    sweep_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        dp_req = 1'b1;
        busy   = 1'b1;
        if (dp_ack && last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        sweep_done = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Unknown behaviour codes are folded to RS at write time so dp_type is always legal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_mem[i]   <= V_REST;
        u_mem[i]   <= U_REST;
        cur_mem[i] <= '0;
        typ_mem[i] <= '0;
      end
    end else begin
      if (cfg_hit) begin
        cur_mem[cfg_addr] <= cfg_current;
        typ_mem[cfg_addr] <= (cfg_type > MAX_TYPE) ? 4'd0 : cfg_type;
      end
      if (init_ok) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
          v_mem[i] <= V_REST;
          u_mem[i] <= U_REST;
        end
      end else if (ack_ok) begin
        v_mem[idx] <= dp_v_next;
        u_mem[idx] <= dp_u_next;
      end
    end
  end

  // The last ack folds its spike straight into spike_vec so it is visible during DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      acc        <= '0;
      spike_vec  <= '0;
      overrun    <= 1'b0;
      dp_v       <= '0;
      dp_u       <= '0;
      dp_current <= '0;
      dp_type    <= '0;
    end else begin
      if (busy && tick) begin
        overrun <= 1'b1;
      end
      if (start) begin
        idx        <= '0;
        acc        <= '0;
        dp_v       <= v_mem[0];
        dp_u       <= u_mem[0];
        dp_current <= cur_mem[0];
        dp_type    <= typ_mem[0];
      end
      if (ack_ok) begin
        acc[idx] <= dp_spike;
        if (last) begin
          spike_vec <= acc | (NUM_NEURONS'(dp_spike) << idx);
        end else begin
          idx        <= idx_inc;
          dp_v       <= v_mem[idx_inc];
          dp_u       <= u_mem[idx_inc];
          dp_current <= cur_mem[idx_inc];
          dp_type    <= typ_mem[idx_inc];
        end
      end
    end
  end

endmodule
